seq_chunk_adder: RTL

//   Parametrised multi-cycle ripple-carry adder/subtractor.

---
 rtl/seq_chunk_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with a start/done handshake, carry-out and signed-overflow flags.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   rc;
    logic [CHUNK-1:0] chunk_sum;

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right one chunk per cycle, so the active slice is always the low CHUNK bits.
    always_comb begin
        rc[0] = carry;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = op_a[i] ^ op_b[i] ^ rc[i];
            rc[i+1]      = (op_a[i] & op_b[i]) | (rc[i] & (op_a[i] ^ op_b[i]));
        end
        acc_next = (acc >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
    end

    // Subtract is a + ~b + ~c_in, so b and the carry are inverted once at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= c_in ^ sub;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            acc   <= acc_next;
            carry <= rc[CHUNK];
            if (cnt == LAST_CNT) begin
                s     <= acc_next;
                c_out <= rc[CHUNK];
                ovf   <= rc[CHUNK] ^ rc[CHUNK-1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
